// File: rtl/sd_cmd_pad_ctrl_if.sv
// Interface for sd_cmd_pad_ctrl. It carries the command handshake, the pad controls
// and the response. The master is the upstream command engine and pad model; the slave is the controller.
interface sd_cmd_pad_ctrl_if #(
  parameter int CMD_WIDTH  = 48,
  parameter int RESP_WIDTH = 48
);
  logic                  start;
  logic [CMD_WIDTH-1:0]  cmd_in;
  logic                  resp_expected;
  logic                  pad_data_out;
  logic                  output_input;
  logic                  enable;
  logic                  data_in;
  logic                  busy;
  logic                  done;
  logic                  timeout;
  logic [RESP_WIDTH-1:0] response;
  logic                  crc_error;

  modport master (
    output start, cmd_in, resp_expected, pad_data_out,
    input  output_input, enable, data_in, busy, done, timeout, response, crc_error
  );

  modport slave (
    input  start, cmd_in, resp_expected, pad_data_out,
    output output_input, enable, data_in, busy, done, timeout, response, crc_error
  );
endinterface

// File: rtl/sd_cmd_pad_ctrl.sv
// SD CMD-line pad sequencer: it sends a command, turns the line around, hunts for the start bit and
// receives the response. Defining CMD_CRC7_EN inserts a CRC7 into the command and checks the response CRC.
module sd_cmd_pad_ctrl #(
  parameter int CMD_WIDTH   = 48,
  parameter int RESP_WIDTH  = 48,
  parameter int TURN_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input logic              sd_clock,
  input logic              reset,
  sd_cmd_pad_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_TURN = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RECV = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam int CW = 16;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [RESP_WIDTH-2:0] shift_q, shift_d;
  logic [RESP_WIDTH-1:0] resp_q, resp_d, frame;
  logic                  resp_exp_q, resp_exp_d;
  logic                  oi_q, oi_d, en_q, din_q, din_d;
  logic                  busy_q, done_q, done_d, tmo_q, tmo_d;

  // The start bit is the zero left in shift_q when the hunt ends, so it lands in the frame MSB.
  assign frame = {shift_q, bus.pad_data_out};

`ifdef CMD_CRC7_EN
  logic [6:0] crc_q, crc_d;
  logic       crc_bad_q, crc_bad_d, crc_err_q, crc_err_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_i);
    logic fb;
    fb = bit_i ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    shift_d    = shift_q;
    resp_d     = resp_q;
    resp_exp_d = resp_exp_q;
    oi_d       = 1'b1;
    din_d      = 1'b1;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
`ifdef CMD_CRC7_EN
    crc_d      = crc_q;
    crc_bad_d  = crc_bad_q;
    crc_err_d  = crc_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_d      = bus.cmd_in;
          resp_exp_d = bus.resp_expected;
          cnt_d      = '0;
          state_d    = S_SEND;
`ifdef CMD_CRC7_EN
          crc_d      = '0;
          crc_bad_d  = 1'b0;
          crc_err_d  = 1'b0;
`endif
        end
      end
      S_SEND: begin
        din_d = cmd_q[CMD_WIDTH-1];
`ifdef CMD_CRC7_EN
        // The CRC register is built over the payload and then shifted out in place of bits [7:1].
        if (cnt_q < CW'(CMD_WIDTH-8)) begin
          crc_d = crc7_step(crc_q, cmd_q[CMD_WIDTH-1]);
        end else if (cnt_q < CW'(CMD_WIDTH-1)) begin
          din_d = crc_q[6];
          crc_d = {crc_q[5:0], 1'b0};
        end
`endif
        cmd_d = {cmd_q[CMD_WIDTH-2:0], 1'b0};
        if (cnt_q == CW'(CMD_WIDTH-1)) begin
          cnt_d   = '0;
          state_d = resp_exp_q ? S_TURN : S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TURN: begin
        oi_d = 1'b0;
        if (cnt_q == CW'(TURN_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        oi_d = 1'b0;
        if (!bus.pad_data_out) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = S_RECV;
`ifdef CMD_CRC7_EN
          crc_d   = '0;
`endif
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          tmo_d   = 1'b1;
          oi_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECV: begin
        oi_d    = 1'b0;
        shift_d = frame[RESP_WIDTH-2:0];
`ifdef CMD_CRC7_EN
        if (cnt_q < CW'(RESP_WIDTH-9)) crc_d = crc7_step(crc_q, bus.pad_data_out);
`endif
        if (cnt_q == CW'(RESP_WIDTH-2)) begin
          resp_d  = frame;
          cnt_d   = '0;
          state_d = S_DONE;
`ifdef CMD_CRC7_EN
          crc_bad_d = (crc_q != frame[7:1]);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef CMD_CRC7_EN
        crc_err_d = crc_bad_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      shift_q    <= '0;
      resp_q     <= '0;
      resp_exp_q <= 1'b0;
      oi_q       <= 1'b1;
      en_q       <= 1'b0;
      din_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      shift_q    <= shift_d;
      resp_q     <= resp_d;
      resp_exp_q <= resp_exp_d;
      oi_q       <= oi_d;
      en_q       <= 1'b1;
      din_q      <= din_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef CMD_CRC7_EN
  always_ff @(posedge sd_clock) begin
    if (reset) begin
      crc_q     <= '0;
      crc_bad_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      crc_q     <= crc_d;
      crc_bad_q <= crc_bad_d;
      crc_err_q <= crc_err_d;
    end
  end
  assign bus.crc_error = crc_err_q;
`else
  assign bus.crc_error = 1'b0;
`endif

  assign bus.output_input = oi_q;
  assign bus.enable       = en_q;
  assign bus.data_in      = din_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.timeout      = tmo_q;
  assign bus.response     = resp_q;

endmodule

// File: tb/tb_sd_cmd_pad_ctrl.sv
// Bench for sd_cmd_pad_ctrl: table vectors, hand sequences and random transactions are
// checked against a transaction-level model. Defining CMD_CRC7_EN also checks the CRC build.
`timescale 1ns/1ps
module tb_sd_cmd_pad_ctrl;
  localparam int CMD_W  = 48;
  localparam int RESP_W = 48;
  localparam int TURN   = 2;
  localparam int TMO    = 64;

  typedef struct {
    logic [CMD_W-1:0]  cmd;
    logic              re;
    int                w;
    logic [RESP_W-1:0] frame;
    int                expLat;
    logic              expTmo;
    logic [RESP_W-1:0] expResp;
  } vec_t;

  logic              sd_clock = 1'b0;
  logic              reset;
  int                errors = 0;
  int                checks = 0;
  logic [RESP_W-1:0] expResp = '0;
  vec_t              vecs[7];

  sd_cmd_pad_ctrl_if #(.CMD_WIDTH(CMD_W), .RESP_WIDTH(RESP_W)) bus ();

  sd_cmd_pad_ctrl #(
    .CMD_WIDTH(CMD_W), .RESP_WIDTH(RESP_W), .TURN_CYCLES(TURN), .TIMEOUT(TMO)
  ) dut (
    .sd_clock(sd_clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [39:0] msg);
    logic [46:0] rem;
    rem = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
    return rem[6:0];
  endfunction

  function automatic logic [CMD_W-1:0] txFrame(input logic [CMD_W-1:0] cmd);
`ifdef CMD_CRC7_EN
    return {cmd[CMD_W-1:8], crc7(cmd[CMD_W-1:8]), cmd[0]};
`else
    return cmd;
`endif
  endfunction

  function automatic logic respCrcBad(input logic [RESP_W-1:0] f);
`ifdef CMD_CRC7_EN
    return crc7(f[RESP_W-1:8]) != f[7:1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkResetValues(input string name);
    checkOutput({name, " output_input"}, 64'(bus.output_input), 64'd1);
    checkOutput({name, " enable"}, 64'(bus.enable), 64'd0);
    checkOutput({name, " data_in"}, 64'(bus.data_in), 64'd1);
    checkOutput({name, " busy"}, 64'(bus.busy), 64'd0);
    checkOutput({name, " done"}, 64'(bus.done), 64'd0);
    checkOutput({name, " timeout"}, 64'(bus.timeout), 64'd0);
    checkOutput({name, " response"}, 64'(bus.response), 64'd0);
    checkOutput({name, " crc_error"}, 64'(bus.crc_error), 64'd0);
  endtask

  // One transaction: the model gives the end cycle and the per-cycle pad behaviour from the timing rules.
  task automatic applyStimulus(input string name, input logic [CMD_W-1:0] cmd, input logic re,
                               input int w, input logic [RESP_W-1:0] frame, input int injectAt,
                               input int abortAt, output int obsEnd, output logic obsTmo,
                               output logic obsCrc, output logic [CMD_W-1:0] txCap);
    logic [CMD_W-1:0]  tx;
    logic [RESP_W-1:0] newResp;
    logic              isTmo, expCrc, aborted;
    int                endT, j;
    tx      = txFrame(cmd);
    isTmo   = re && (w >= TMO);
    endT    = !re ? CMD_W + 1 : (isTmo ? CMD_W + TURN + TMO : CMD_W + TURN + w + RESP_W + 1);
    newResp = (re && !isTmo) ? frame : expResp;
    expCrc  = re && !isTmo && respCrcBad(frame);
    obsEnd  = -1;
    obsTmo  = 1'b0;
    obsCrc  = 1'b0;
    txCap   = '0;
    aborted = 1'b0;
    bus.cmd_in        = cmd;
    bus.resp_expected = re;
    bus.start         = 1'b1;
    @(posedge sd_clock); #1;
    bus.start = 1'b0;
    for (int t = 0; t <= endT; t++) begin
      checkOutput($sformatf("%s t=%0d done", name, t), 64'(bus.done), 64'(t == endT && !isTmo));
      checkOutput($sformatf("%s t=%0d timeout", name, t), 64'(bus.timeout), 64'(t == endT && isTmo));
      checkOutput($sformatf("%s t=%0d busy", name, t), 64'(bus.busy), 64'(t < endT));
      checkOutput($sformatf("%s t=%0d output_input", name, t), 64'(bus.output_input),
                  64'(!(re && t > CMD_W && t < endT)));
      checkOutput($sformatf("%s t=%0d enable", name, t), 64'(bus.enable), 64'd1);
      checkOutput($sformatf("%s t=%0d data_in", name, t), 64'(bus.data_in),
                  64'((t >= 1 && t <= CMD_W) ? tx[CMD_W - t] : 1'b1));
      if (t >= 1 && t <= CMD_W) txCap[CMD_W - t] = bus.data_in;
      if (obsEnd < 0 && (bus.done || bus.timeout)) begin
        obsEnd = t;
        obsTmo = bus.timeout;
      end
      if (t == endT) begin
        obsCrc = bus.crc_error;
        checkOutput({name, " response"}, 64'(bus.response), 64'(newResp));
        checkOutput({name, " crc_error"}, 64'(bus.crc_error), 64'(expCrc));
      end
      j = t + 1 - (CMD_W + TURN + 1);
      if (j < 0) bus.pad_data_out = 1'($urandom_range(0, 1));
      else if (isTmo || j < w) bus.pad_data_out = 1'b1;
      else if (j < w + RESP_W) bus.pad_data_out = frame[RESP_W - 1 - (j - w)];
      else bus.pad_data_out = 1'b1;
      if (t == injectAt) begin
        bus.start         = 1'b1;
        bus.cmd_in        = ~cmd;
        bus.resp_expected = ~re;
      end else begin
        bus.start = 1'b0;
      end
      if (t == abortAt) begin
        reset = 1'b1;
        @(posedge sd_clock); #1;
        checkResetValues({name, " abort"});
        reset   = 1'b0;
        expResp = '0;
        aborted = 1'b1;
        break;
      end
      if (t < endT) begin
        @(posedge sd_clock); #1;
      end
    end
    bus.start        = 1'b0;
    bus.pad_data_out = 1'b1;
    if (!aborted) expResp = newResp;
    @(posedge sd_clock); #1;
    checkOutput({name, " idle busy"}, 64'(bus.busy), 64'd0);
    checkOutput({name, " idle data_in"}, 64'(bus.data_in), 64'd1);
    checkOutput({name, " idle output_input"}, 64'(bus.output_input), 64'd1);
    checkOutput({name, " idle enable"}, 64'(bus.enable), 64'd1);
    checkOutput({name, " idle done"}, 64'(bus.done), 64'd0);
    checkOutput({name, " idle timeout"}, 64'(bus.timeout), 64'd0);
  endtask

  initial begin
    int               obsEnd;
    logic             obsTmo, obsCrc;
    logic [CMD_W-1:0] txCap, rc;
    logic [63:0]      r;
    logic [RESP_W-1:0] fr;
    int               w, inj;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.cmd_in = '0;
    bus.resp_expected = 1'b0;
    bus.pad_data_out = 1'b1;
    repeat (2) @(posedge sd_clock);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge sd_clock); #1;
      checkOutput($sformatf("idle%0d output_input", i), 64'(bus.output_input), 64'd1);
      checkOutput($sformatf("idle%0d enable", i), 64'(bus.enable), 64'd1);
      checkOutput($sformatf("idle%0d data_in", i), 64'(bus.data_in), 64'd1);
      checkOutput($sformatf("idle%0d busy", i), 64'(bus.busy), 64'd0);
    end

    vecs[0] = '{48'h40_0000_0000_95, 1'b0, 0,  48'h0,               49,  1'b0, 48'h0};
    vecs[1] = '{48'h48_0000_01AA_01, 1'b1, 5,  48'h08_0000_01AA_13, 104, 1'b0, 48'h08_0000_01AA_13};
    vecs[2] = '{48'h77_0000_0000_65, 1'b1, 64, 48'h0,               114, 1'b1, 48'h08_0000_01AA_13};
    vecs[3] = '{48'h51_0000_1000_55, 1'b1, 0,  48'h3F_1234_5678_9B, 99,  1'b0, 48'h3F_1234_5678_9B};
    vecs[4] = '{48'hFF_FFFF_FFFF_FF, 1'b1, 63, 48'h00_FFFF_FFFF_FF, 162, 1'b0, 48'h00_FFFF_FFFF_FF};
    vecs[5] = '{48'h00_0000_0000_00, 1'b0, 0,  48'h0,               49,  1'b0, 48'h00_FFFF_FFFF_FF};
    vecs[6] = '{48'h52_0000_0000_01, 1'b1, 70, 48'h0,               114, 1'b1, 48'h00_FFFF_FFFF_FF};

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].re, vecs[i].w, vecs[i].frame,
                    -1, -1, obsEnd, obsTmo, obsCrc, txCap);
      checkOutput($sformatf("vec%0d latency", i), 64'(obsEnd), 64'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d timeout flag", i), 64'(obsTmo), 64'(vecs[i].expTmo));
      checkOutput($sformatf("vec%0d held response", i), 64'(bus.response), 64'(vecs[i].expResp));
      if (i == 0) checkOutput("vec0 serial frame", 64'(txCap), 64'h40_0000_0000_95);
    end

    applyStimulus("inject_nores", 48'h4C_1234_5678_9A, 1'b0, 0, 48'h0, 10, -1,
                  obsEnd, obsTmo, obsCrc, txCap);
    checkOutput("inject_nores latency", 64'(obsEnd), 64'd49);
    applyStimulus("abort_recv", 48'h45_0F0F_0F0F_0F, 1'b1, 3, 48'h2A_5555_AAAA_33, 20,
                  CMD_W + TURN + 3 + 20, obsEnd, obsTmo, obsCrc, txCap);
    applyStimulus("after_abort", 48'h41_0000_0000_01, 1'b1, 1, 48'h11_2233_4455_67, -1, -1,
                  obsEnd, obsTmo, obsCrc, txCap);
    checkOutput("after_abort latency", 64'(obsEnd), 64'(CMD_W + TURN + 1 + RESP_W + 1));

`ifdef CMD_CRC7_EN
    applyStimulus("crc_cmd8", 48'h48_0000_01AA_01, 1'b0, 0, 48'h0, -1, -1,
                  obsEnd, obsTmo, obsCrc, txCap);
    checkOutput("crc_cmd8 last byte", 64'(txCap[7:0]), 64'h87);
    fr = {40'h08_0000_01AA, crc7(40'h08_0000_01AA), 1'b1};
    applyStimulus("crc_good", 48'h48_0000_01AA_01, 1'b1, 2, fr, -1, -1,
                  obsEnd, obsTmo, obsCrc, txCap);
    checkOutput("crc_good flag", 64'(obsCrc), 64'd0);
    fr[20] = ~fr[20];
    applyStimulus("crc_bad", 48'h48_0000_01AA_01, 1'b1, 2, fr, -1, -1,
                  obsEnd, obsTmo, obsCrc, txCap);
    checkOutput("crc_bad flag", 64'(obsCrc), 64'd1);
`endif

    for (int i = 0; i < 14; i++) begin
      r   = {$urandom(), $urandom()};
      rc  = r[CMD_W-1:0];
      r   = {$urandom(), $urandom()};
      fr  = {1'b0, r[RESP_W-2:0]};
      w   = $urandom_range(0, TMO + 3);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 40) : -1;
      applyStimulus($sformatf("rnd%0d", i), rc, 1'($urandom_range(0, 1)), w, fr, inj, -1,
                    obsEnd, obsTmo, obsCrc, txCap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sd_cmd_pad_ctrl.md
Name: sd_cmd_pad_ctrl

Overview:
- Sequencer for the SD CMD-line bidirectional pad.
- Owns the pad controls `output_input`, `enable` and `data_in`.
- Serializes a host command onto the line, releases the line, and hunts for the card's response start bit with a timeout.
- Deserializes the response and reports done or timeout to the upstream command engine.

Parameters:
- CMD_WIDTH, 48: command frame length in bits, sent MSB first.
- RESP_WIDTH, 48: response frame length in bits, including the start bit.
- TURN_CYCLES, 2: number of cycles the line is released before the start-bit hunt begins.
- TIMEOUT, 64: number of WAIT cycles without a start bit before the controller aborts.

Ports:
- sd_clock  in  1  block clock; everything is registered on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- cmd_in  in  CMD_WIDTH  command frame; captured on the accepted start.
- resp_expected  in  1  captured with start; 0 means no response phase.
- pad_data_out  in  1  line value sampled from the pad.
- output_input  out  1  pad direction: 1 = drive the line, 0 = receive.
- enable  out  1  pad enable.
- data_in  out  1  serial bit presented to the pad.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout  out  1  one-cycle pulse when the start-bit hunt times out.
- response  out  RESP_WIDTH  last received frame; held until the next RECV.
- crc_error  out  1  response CRC mismatch flag (see Optional Feature).

Behaviour:
- Reset values: `output_input`=1, `enable`=0, `data_in`=1, `busy`=0, `done`=0, `timeout`=0, `response`=0, `crc_error`=0, state=IDLE.
- Reset asserted mid-operation: all reset values apply on the next edge; any partial frame is discarded.
- All outputs are registered.
- IDLE:
  - `enable`=1, `output_input`=1, `data_in`=1 (line idles high).
  - `start`=1: latch `cmd_in` and `resp_expected`, go to SEND.
- SEND: one bit per cycle.
  - In SEND cycle k (k = 0..CMD_WIDTH-1), `data_in` = latched_cmd[CMD_WIDTH-1-k].
  - The first bit appears on `data_in` the cycle after the accepted `start`.
  - After the last bit: go to DONE if `resp_expected`=0, otherwise go to TURN.
- TURN:
  - `output_input`=0, `data_in`=1, for TURN_CYCLES cycles.
  - `pad_data_out` is ignored; then go to WAIT.
- WAIT:
  - `output_input`=0; sample `pad_data_out` every cycle; a wait counter starts at 0.
  - Sample = 0: this is the start bit. It is stored as response bit RESP_WIDTH-1; go to RECV.
  - Counter reaches TIMEOUT-1 with no 0 seen: pulse `timeout`, set `output_input`=1, go to IDLE. `response` is unchanged.
  - A 0 seen on the same cycle the counter expires counts as a start bit (start bit wins).
- RECV:
  - Shift `pad_data_out` in MSB first for the remaining RESP_WIDTH-1 cycles.
  - On the final bit: write the complete frame to `response`, go to DONE.
- DONE: pulse `done` for one cycle, set `output_input`=1, return to IDLE.
- `start` while `busy`=1 is ignored and not queued.
- `done` and `timeout` are never high together.
- Latency, no response: `start` at edge N gives `done`=1 in cycle N+CMD_WIDTH+1.
- Latency, with response: N+CMD_WIDTH+TURN_CYCLES+W+RESP_WIDTH+1, where W is the number of WAIT cycles before the start bit.

Optional Feature:
- Macro: CMD_CRC7_EN.
- Defined:
  - SEND replaces latched_cmd[7:1] with the CRC7 (polynomial x^7+x^3+1, init 0) computed over bits [CMD_WIDTH-1:8], generated bit-serially during SEND.
  - RECV computes CRC7 over response bits [RESP_WIDTH-1:8] and compares it with bits [7:1].
  - `crc_error` is set on the DONE edge on mismatch and cleared on the next accepted `start`.
- Undefined: the command is sent verbatim and `crc_error` is tied 0.

Test Plan:
- Reset, then idle → `output_input`=1, `enable`=1, `data_in`=1, `busy`=0 for at least 10 cycles.
- `cmd_in`=48'h40_0000_0000_95, `resp_expected`=0 → `data_in` carries 0,1,0,0,0,0,0,0 … 1,0,0,1,0,1,0,1; `done` in cycle N+49; `output_input` stays 1 throughout.
- `resp_expected`=1; bench holds `pad_data_out`=1 for 5 WAIT cycles, then drives 48'h08_0000_01AA_13 MSB first → `output_input`=0 from N+49; `done` pulses; `response`=48'h08_0000_01AA_13.
- `resp_expected`=1, `pad_data_out` stuck at 1 → `timeout` pulses exactly 64 cycles after WAIT entry; `response` unchanged; state returns to IDLE.
- Pulse `start` mid-SEND, then assert `reset` mid-RECV → the second `start` is ignored; after reset, all reset values are present on the next edge.
- With CMD_CRC7_EN defined:
  - `cmd_in`=48'h48_0000_01AA_01 → last transmitted byte is 8'h87.
  - A response frame with one corrupted bit → `crc_error`=1 together with `done`.
